// File: rtl/rgb_button_sequencer.sv
// Status-LED controller: debounced push-button selects colour (short press) and
// brightness (long press with auto-repeat); the selected colour is PWM-driven on rgb.
module rgb_button_sequencer #(
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int HOLD_CYCLES     = 5000000,
  parameter int PWM_WIDTH       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 button,
  output logic [2:0]           rgb,
  output logic [1:0]           color,
  output logic [PWM_WIDTH-1:0] level,
  output logic                 short_press,
  output logic                 long_step
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HW = $clog2(HOLD_CYCLES) + 1;

  localparam logic [DW-1:0]        DEB_ONE   = DW'(1);
  localparam logic [DW-1:0]        DEB_LAST  = DW'(DEBOUNCE_CYCLES);
  localparam logic [HW-1:0]        HOLD_ONE  = HW'(1);
  localparam logic [HW-1:0]        HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [PWM_WIDTH-1:0] LVL_ONE   = PWM_WIDTH'(1);
  localparam logic [PWM_WIDTH-1:0] LVL_MAX   = {PWM_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_DEB_PRESS   = 3'd1,
    S_PRESSED     = 3'd2,
    S_HOLD        = 3'd3,
    S_DEB_RELEASE = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic                 from_hold_q, from_hold_d;
  logic [DW-1:0]        deb_cnt_q, deb_cnt_d;
  logic [HW-1:0]        hold_cnt_q, hold_cnt_d;
  logic [1:0]           color_q, color_d;
  logic [PWM_WIDTH-1:0] level_q, level_d;
  logic [PWM_WIDTH-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [2:0]           rgb_q, rgb_d;
  logic                 short_q, short_d;
  logic                 long_q, long_d;
  logic                 step_s;
  logic                 btn_s;

  function automatic logic [1:0] next_color(input logic [1:0] c);
    logic [1:0] n;
    case (c)
      2'd0:    n = 2'd1;
      2'd1:    n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

  function automatic logic [2:0] color_onehot(input logic [1:0] c);
    logic [2:0] oh;
    case (c)
      2'd0:    oh = 3'b100;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b001;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  assign btn_s = sync2_q;

  // Next-state logic: synchroniser, PWM, press classification FSM, colour/level.
  always_comb begin
    sync1_d     = button;
    sync2_d     = sync1_q;
    pwm_cnt_d   = pwm_cnt_q + LVL_ONE;
    state_d     = state_q;
    from_hold_d = from_hold_q;
    deb_cnt_d   = deb_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    color_d     = color_q;
    level_d     = level_q;
    short_d     = 1'b0;
    long_d      = 1'b0;
    step_s      = 1'b0;
    rgb_d       = 3'b000;

    if (ena && (pwm_cnt_q < level_q)) begin
      rgb_d = color_onehot(color_q);
    end else begin
      rgb_d = 3'b000;
    end

    if (!ena) begin
      state_d     = S_IDLE;
      from_hold_d = 1'b0;
      deb_cnt_d   = '0;
      hold_cnt_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (btn_s) begin
            state_d   = S_DEB_PRESS;
            deb_cnt_d = DEB_ONE;
          end else begin
            deb_cnt_d = '0;
          end
        end
        S_DEB_PRESS: begin
          if (!btn_s) begin
            state_d   = S_IDLE;
            deb_cnt_d = '0;
          end else if (deb_cnt_q + DEB_ONE == DEB_LAST) begin
            state_d    = S_PRESSED;
            deb_cnt_d  = '0;
            hold_cnt_d = '0;
          end else begin
            deb_cnt_d = deb_cnt_q + DEB_ONE;
          end
        end
        S_PRESSED, S_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            step_s     = 1'b1;
            long_d     = 1'b1;
            hold_cnt_d = '0;
            state_d    = S_HOLD;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_ONE;
            state_d    = state_q;
          end
          // A step landing on the release cycle still turns this into a long press.
          if (!btn_s) begin
            from_hold_d = (state_d == S_HOLD);
            state_d     = S_DEB_RELEASE;
            deb_cnt_d   = DEB_ONE;
          end else begin
            from_hold_d = from_hold_q;
          end
        end
        S_DEB_RELEASE: begin
          if (btn_s) begin
            state_d   = from_hold_q ? S_HOLD : S_PRESSED;
            deb_cnt_d = '0;
          end else if (deb_cnt_q + DEB_ONE == DEB_LAST) begin
            state_d     = S_IDLE;
            deb_cnt_d   = '0;
            hold_cnt_d  = '0;
            from_hold_d = 1'b0;
            if (!from_hold_q) begin
              color_d = next_color(color_q);
              short_d = 1'b1;
            end else begin
              color_d = color_q;
            end
          end else begin
            deb_cnt_d = deb_cnt_q + DEB_ONE;
          end
        end
        default: begin
          state_d     = S_IDLE;
          from_hold_d = 1'b0;
          deb_cnt_d   = '0;
          hold_cnt_d  = '0;
        end
      endcase
    end

    // Stepping wraps from full brightness to 1 so the LED never goes dark.
    if (step_s) begin
      if (level_q == LVL_MAX) begin
        level_d = LVL_ONE;
      end else begin
        level_d = level_q + LVL_ONE;
      end
    end else begin
      level_d = level_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      from_hold_q <= 1'b0;
      deb_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      color_q     <= 2'd0;
      level_q     <= LVL_MAX;
      pwm_cnt_q   <= '0;
      rgb_q       <= 3'b000;
      short_q     <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      from_hold_q <= from_hold_d;
      deb_cnt_q   <= deb_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      color_q     <= color_d;
      level_q     <= level_d;
      pwm_cnt_q   <= pwm_cnt_d;
      rgb_q       <= rgb_d;
      short_q     <= short_d;
      long_q      <= long_d;
    end
  end

  assign rgb         = rgb_q;
  assign color       = color_q;
  assign level       = level_q;
  assign short_press = short_q;
  assign long_step   = long_q;

endmodule

// File: tb/tb_rgb_button_sequencer.sv
// Bench for rgb_button_sequencer: phase table, directed corner sequences and random
// button/enable/reset activity, all checked every cycle against a press-level model.
module tb_rgb_button_sequencer;

  localparam int DEB  = 4;
  localparam int HOLD = 20;
  localparam int PW   = 3;
  localparam int LMAX = (1 << PW) - 1;

  logic          clk;
  logic          rst;
  logic          ena;
  logic          button;
  logic [2:0]    rgb;
  logic [1:0]    color;
  logic [PW-1:0] level;
  logic          short_press;
  logic          long_step;

  rgb_button_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES(HOLD),
    .PWM_WIDTH(PW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ena(ena),
    .button(button),
    .rgb(rgb),
    .color(color),
    .level(level),
    .short_press(short_press),
    .long_step(long_step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int seen_short;
  int seen_long;

  // Reference model: press accepted / long-press flag / run lengths of button level.
  bit       m_s1, m_s2;
  bit       m_acc, m_long_flag;
  int       m_run, m_lo, m_held;
  int       m_color, m_level, m_pwm;
  logic [2:0] m_rgb;
  bit       m_short, m_lstep;

  typedef struct {
    bit ena;
    bit btn;
    int n;
    int color;
    int level;
    int shorts;
    int longs;
  } vec_t;

  vec_t tbl[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_s1 = 0; m_s2 = 0; m_acc = 0; m_long_flag = 0;
    m_run = 0; m_lo = 0; m_held = 0;
    m_color = 0; m_level = LMAX; m_pwm = 0;
    m_rgb = 3'b000; m_short = 0; m_lstep = 0;
  endfunction

  function automatic void model_step();
    bit b;
    b = m_s2;
    m_rgb   = (ena && (m_pwm < m_level)) ? (3'b100 >> m_color) : 3'b000;
    m_short = 0;
    m_lstep = 0;
    if (!ena) begin
      m_acc = 0; m_run = 0; m_lo = 0; m_held = 0;
    end else if (!m_acc) begin
      m_run = b ? m_run + 1 : 0;
      if (m_run == DEB) begin
        m_acc = 1; m_run = 0; m_held = 0; m_long_flag = 0;
      end
    end else if (m_lo == 0) begin
      if (m_held == HOLD - 1) begin
        m_level = m_level % LMAX + 1;
        m_lstep = 1; m_long_flag = 1; m_held = 0;
      end else begin
        m_held++;
      end
      if (!b) m_lo = 1;
    end else begin
      m_lo = b ? 0 : m_lo + 1;
      if (m_lo == DEB) begin
        m_acc = 0; m_lo = 0; m_held = 0;
        if (!m_long_flag) begin
          m_color = (m_color + 1) % 3;
          m_short = 1;
        end
      end
    end
    m_pwm = (m_pwm + 1) % (LMAX + 1);
    m_s2 = m_s1;
    m_s1 = button;
  endfunction

  task automatic check_outputs();
    check("rgb", rgb, m_rgb);
    check("color", color, m_color);
    check("level", level, m_level);
    check("short_press", short_press, m_short);
    check("long_step", long_step, m_lstep);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    @(negedge clk);
    check_outputs();
    seen_short += short_press;
    seen_long  += long_step;
  endtask

  task automatic run(input bit e, input bit b, input int n);
    ena = e;
    button = b;
    repeat (n) cycle();
  endtask

  initial begin
    int cnt;
    int lat;
    tbl[0]  = '{1'b1, 1'b0, 16,  0, 7, 0, 0};
    tbl[1]  = '{1'b1, 1'b1, 10,  0, 7, 0, 0};
    tbl[2]  = '{1'b1, 1'b0, 10,  1, 7, 1, 0};
    tbl[3]  = '{1'b1, 1'b1, 10,  1, 7, 0, 0};
    tbl[4]  = '{1'b1, 1'b0, 10,  2, 7, 1, 0};
    tbl[5]  = '{1'b1, 1'b1, 10,  2, 7, 0, 0};
    tbl[6]  = '{1'b1, 1'b0, 10,  0, 7, 1, 0};
    tbl[7]  = '{1'b1, 1'b1, 2,   0, 7, 0, 0};
    tbl[8]  = '{1'b1, 1'b0, 1,   0, 7, 0, 0};
    tbl[9]  = '{1'b1, 1'b1, 3,   0, 7, 0, 0};
    tbl[10] = '{1'b1, 1'b0, 10,  0, 7, 0, 0};
    tbl[11] = '{1'b1, 1'b1, 70,  0, 3, 0, 3};
    tbl[12] = '{1'b1, 1'b0, 10,  0, 3, 0, 0};
    tbl[13] = '{1'b1, 1'b1, 110, 0, 1, 0, 5};
    tbl[14] = '{1'b1, 1'b0, 10,  0, 1, 0, 0};
    tbl[15] = '{1'b1, 1'b1, 12,  0, 1, 0, 0};
    tbl[16] = '{1'b1, 1'b0, 2,   0, 1, 0, 0};
    tbl[17] = '{1'b1, 1'b1, 8,   0, 1, 0, 0};
    tbl[18] = '{1'b1, 1'b0, 10,  1, 1, 1, 0};

    seen_short = 0;
    seen_long  = 0;
    rst = 1'b1;
    ena = 1'b0;
    button = 1'b0;
    model_reset();
    repeat (2) cycle();
    rst = 1'b0;

    // Full-brightness duty: 7 of every 8 cycles red.
    ena = 1'b1;
    cnt = 0;
    repeat (16) begin
      cycle();
      if (rgb == 3'b100) cnt++;
    end
    check("duty_level7", cnt, 14);
    ena = 1'b0;
    cycle();
    check("ena_off_rgb", rgb, 3'b000);

    for (int i = 0; i < 19; i++) begin
      seen_short = 0;
      seen_long  = 0;
      run(tbl[i].ena, tbl[i].btn, tbl[i].n);
      check($sformatf("tbl%0d_color", i), color, tbl[i].color);
      check($sformatf("tbl%0d_level", i), level, tbl[i].level);
      check($sformatf("tbl%0d_shorts", i), seen_short, tbl[i].shorts);
      check($sformatf("tbl%0d_longs", i), seen_long, tbl[i].longs);
    end

    // Short-press latency from the release edge.
    run(1'b1, 1'b1, 10);
    button = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      if (short_press === 1'b1 && lat == 0) lat = i;
    end
    check("short_latency", lat, 6);
    check("color_after_latency", color, 2);

    // Level 1 duty: blue on 1 of every 8 cycles.
    cnt = 0;
    repeat (16) begin
      cycle();
      if (rgb == 3'b001) cnt++;
    end
    check("duty_level1", cnt, 2);

    // Reset pulse while PRESSED.
    run(1'b1, 1'b1, 8);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_rgb", rgb, 3'b000);
    check("rst_color", color, 0);
    check("rst_level", level, 7);
    check("rst_short", short_press, 1'b0);
    check("rst_long", long_step, 1'b0);
    @(negedge clk);
    cycle();
    rst = 1'b0;
    seen_long = 0;
    seen_short = 0;
    run(1'b1, 1'b1, 30);
    check("post_rst_level", level, 1);
    check("post_rst_longs", seen_long, 1);
    run(1'b1, 1'b0, 10);
    check("post_rst_shorts", seen_short, 0);

    // Enable drop during HOLD, then re-debounce while still held.
    run(1'b1, 1'b1, 30);
    check("hold_level", level, 2);
    seen_long = 0;
    ena = 1'b0;
    cycle();
    check("ena_drop_rgb", rgb, 3'b000);
    run(1'b0, 1'b1, 30);
    check("ena_drop_longs", seen_long, 0);
    check("ena_drop_level", level, 2);
    run(1'b1, 1'b1, 30);
    check("reenable_level", level, 3);
    seen_short = 0;
    run(1'b1, 1'b0, 10);
    check("reenable_shorts", seen_short, 0);
    check("reenable_color", color, 0);

    // Release seen on the exact cycle of the first level step.
    seen_short = 0;
    seen_long = 0;
    run(1'b1, 1'b1, 23);
    run(1'b1, 1'b0, 12);
    check("coinc_level", level, 4);
    check("coinc_longs", seen_long, 1);
    check("coinc_shorts", seen_short, 0);
    check("coinc_color", color, 0);

    // Random activity against the model.
    for (int s = 0; s < 80; s++) begin
      if ($urandom_range(0, 19) == 0) begin
        #1;
        rst = 1'b1;
        model_reset();
        cycle();
        rst = 1'b0;
      end else begin
        run(($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), $urandom_range(1, 30));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rgb_button_sequencer.md
Name: rgb_button_sequencer

Overview:
Clocked controller for the tri-colour status LED. Takes a raw mechanical push-button, synchronises and debounces it, and classifies each press as short or long. A short press advances the colour RED -> GREEN -> BLUE -> RED. A long press steps the brightness level, auto-repeating while held. The block drives the one-hot rgb pins with a PWM waveform set by the current level, replacing the button-clocked colour logic.

Parameters:
DEBOUNCE_CYCLES, 10000, consecutive stable synchronised cycles required to accept a press or a release (>=2)
HOLD_CYCLES, 5000000, cycles a press must stay held before the first level step; also the auto-repeat interval
PWM_WIDTH, 4, width of the brightness level and of the PWM counter

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
ena  input  1  global enable; low blanks the LED and suspends button handling
button  input  1  raw, asynchronous, bouncing push-button (high = pressed)
rgb  output  3  LED drive, one-hot {R,G,B}, PWM-modulated, registered
color  output  2  current colour: 0=RED, 1=GREEN, 2=BLUE (3 never produced)
level  output  PWM_WIDTH  current brightness level
short_press  output  1  one-cycle pulse when a short press completes
long_step  output  1  one-cycle pulse on each level step

Behaviour:
- Reset (async, rst=1): color=RED, level=all ones, rgb=000, short_press=0, long_step=0, FSM=IDLE, all counters=0, synchroniser flops=0.
- button passes through a 2-flop synchroniser; btn_s below is the synchronised value.
- FSM states: IDLE, DEB_PRESS, PRESSED, HOLD, DEB_RELEASE. DEB_RELEASE records its origin (PRESSED or HOLD).
- IDLE: when btn_s=1, go to DEB_PRESS with deb_cnt=1.
- DEB_PRESS: if btn_s=1, increment deb_cnt. When deb_cnt reaches DEBOUNCE_CYCLES, go to PRESSED with hold_cnt=0. If btn_s=0 in any cycle, return to IDLE (bounce rejected, no event).
- PRESSED: hold_cnt increments every cycle. When hold_cnt reaches HOLD_CYCLES-1, step the level, pulse long_step, go to HOLD, and clear hold_cnt.
- HOLD: every HOLD_CYCLES cycles, step the level again and pulse long_step.
- PRESSED or HOLD with btn_s=0: go to DEB_RELEASE with deb_cnt=1. hold_cnt pauses while in DEB_RELEASE.
- DEB_RELEASE with btn_s=1: return to the origin state, clear deb_cnt, and resume hold_cnt from its paused value.
- DEB_RELEASE when DEBOUNCE_CYCLES consecutive low cycles are reached: go to IDLE.
  - If origin was PRESSED: advance color (RED->GREEN, GREEN->BLUE, BLUE->RED) and pulse short_press in the same cycle.
  - If origin was HOLD: no colour change.
- Level step: level+1. At all-ones it wraps to 1, never 0, so the LED is never dark by button action.
- Simultaneous events: a level step and a release in the same cycle both take effect. The step counts, and the origin becomes HOLD.
- PWM:
  - pwm_cnt is a free-running PWM_WIDTH counter that wraps modulo 2^PWM_WIDTH. It runs regardless of ena.
  - on = (pwm_cnt < level). Duty is level/2^PWM_WIDTH.
- rgb is registered, one cycle after pwm_cnt:
  - If ena=1 and on=1: rgb = 100 for RED, 010 for GREEN, 001 for BLUE.
  - Otherwise: rgb = 000.
- ena=0:
  - rgb=000 from the next clock.
  - FSM forced to IDLE; deb_cnt and hold_cnt cleared.
  - No pulses; color and level are retained.
  - A button held while ena rises must be re-debounced from IDLE.
- Reset asserted mid-press: all state returns to reset values immediately, with no pulse. A press still held after reset release is debounced from IDLE.
- Counter widths must hold DEBOUNCE_CYCLES and HOLD_CYCLES without overflow (use $clog2(max)+1).

Test Plan (override DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, PWM_WIDTH=3):
1. Reset then ena=1, no button:
   - Required: color=0, level=7.
   - rgb=100 for 7 of every 8 cycles and 000 for 1; ena=0 gives rgb=000 the next cycle.
2. Clean 10-cycle press then release:
   - Required: one short_press exactly 2+4 cycles after the release edge, color 0->1, level unchanged.
   - Three such presses leave color=0 (wrap).
3. Bouncy press (high 2 cycles, low 1, high 3, then low) -> no short_press, color unchanged.
4. Button held 70 cycles:
   - Required: long_step pulses at 20-cycle spacing after acceptance, level 7->1->2->3 (wrap skips 0).
   - No short_press and no colour change on release.
5. level=1 -> rgb high 1 of 8 cycles. Glitch low for 2 cycles during PRESSED -> returns to PRESSED, no event.
6. Mid-press events:
   - rst pulse while in PRESSED: immediate rgb=000, color=0, level=7, no pulse.
   - ena=0 during HOLD: FSM to IDLE, no further long_step.
